biu_icu_fill_resp: RTL and testbench

BIU_ICU_FILL_RESP -- requirements
Module: biu_icu_fill_resp

---
 rtl/biu_icu_fill_resp.sv | 80 ++++++++
 tb/tb_biu_icu_fill_resp.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/biu_icu_fill_resp.sv
// biu_icu_fill_resp: icache line fill, four ascending 64-bit reads paced out to the icache
module biu_icu_fill_resp #(
  parameter int BEAT_GAP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        icu_biu_req,
  input  logic [31:3] icu_biu_addr,
  output logic        biu_icu_ack,
  output logic        biu_icu_data_valid,
  output logic [63:0] biu_icu_data,
  output logic        biu_icu_data_last,
  output logic        mem_req,
  output logic [31:3] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACK, FILL} state_t;
  localparam int GW = $clog2(BEAT_GAP + 2);
  state_t        state, state_nxt;
  logic [31:5]   base;
  logic [2:0]    issue_cnt, wr_cnt, rd_cnt, out_cnt;
  logic [GW-1:0] gap;
  logic [63:0]   fifo [4];
  logic [63:0]   src;
  logic          active, rv, empty, emit, unused_ok;
  assign active      = state != IDLE;
  assign biu_icu_ack = state == ACK;
  assign mem_req     = active && !issue_cnt[2];
  assign mem_addr    = {base, issue_cnt[1:0]};
  assign rv          = active && mem_rvalid;
  assign empty       = wr_cnt == rd_cnt;
  // an empty buffer forwards the incoming beat straight to the output register
  assign emit        = active && gap == '0 && !out_cnt[2] && (!empty || rv);
  assign src         = empty ? mem_rdata : fifo[rd_cnt[1:0]];
  assign unused_ok   = ^icu_biu_addr[4:3];
  always_comb begin
    state_nxt = state == IDLE ? (icu_biu_req ? ACK : IDLE) :
                state == ACK  ? FILL : (biu_icu_data_last ? IDLE : FILL);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      base               <= '0;
      issue_cnt          <= '0;
      wr_cnt             <= '0;
      rd_cnt             <= '0;
      out_cnt            <= '0;
      gap                <= '0;
      biu_icu_data_valid <= 1'b0;
      biu_icu_data_last  <= 1'b0;
      biu_icu_data       <= '0;
      for (int i = 0; i < 4; i++) fifo[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && icu_biu_req) base <= icu_biu_addr[31:5];
      if (!active) begin
        issue_cnt <= '0;
        wr_cnt    <= '0;
        rd_cnt    <= '0;
        out_cnt   <= '0;
      end else begin
        if (mem_req && mem_gnt) issue_cnt <= issue_cnt + 3'd1;
        if (rv) begin
          fifo[wr_cnt[1:0]] <= mem_rdata;
          wr_cnt            <= wr_cnt + 3'd1;
        end
        if (emit) begin
          rd_cnt  <= rd_cnt + 3'd1;
          out_cnt <= out_cnt + 3'd1;
        end
      end
      gap                <= emit ? GW'(BEAT_GAP) : (gap != '0 ? gap - GW'(1) : gap);
      biu_icu_data_valid <= emit;
      biu_icu_data_last  <= emit && out_cnt == 3'd3;
      if (emit) biu_icu_data <= src;
    end
  end
endmodule

// File: tb/tb_biu_icu_fill_resp.sv
// tb_biu_icu_fill_resp: directed scenarios on a BEAT_GAP=1 and a BEAT_GAP=0 instance sharing one memory model
module tb_biu_icu_fill_resp;
  logic        clk = 1'b0, reset, icu_biu_req, mem_gnt, mem_rvalid;
  logic [31:3] icu_biu_addr, maddr_a, maddr_z;
  logic [63:0] mem_rdata, data_a, data_z;
  logic        ack_a, dv_a, last_a, mreq_a, ack_z, dv_z, last_z, mreq_z;
  int          tests, fails, cyc, n_gnt, stall_beat, stall_left;
  bit          burst;
  logic [63:0] rq[$], da[$], dz[$];
  logic [31:3] ga[$], sa[$];
  bit          la[$], lz[$];
  int          ca[$], cz[$], ac[$];
  logic [63:0] exp_d [4];
  always #5 clk = ~clk;
  biu_icu_fill_resp #(.BEAT_GAP(1)) dut (
    .clk(clk), .reset(reset), .icu_biu_req(icu_biu_req), .icu_biu_addr(icu_biu_addr),
    .biu_icu_ack(ack_a), .biu_icu_data_valid(dv_a), .biu_icu_data(data_a), .biu_icu_data_last(last_a),
    .mem_req(mreq_a), .mem_addr(maddr_a), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));
  biu_icu_fill_resp #(.BEAT_GAP(0)) dut0 (
    .clk(clk), .reset(reset), .icu_biu_req(icu_biu_req), .icu_biu_addr(icu_biu_addr),
    .biu_icu_ack(ack_z), .biu_icu_data_valid(dv_z), .biu_icu_data(data_z), .biu_icu_data_last(last_z),
    .mem_req(mreq_z), .mem_addr(maddr_z), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));
  function automatic logic [63:0] dat(input logic [31:3] a);
    return 64'hbbbb_bbbb_bbbb_bbbb + 64'(a[4:3]) * 64'h1111_1111_1111_1111;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (dv_a) begin da.push_back(data_a); la.push_back(last_a); ca.push_back(cyc); end
    if (dv_z) begin dz.push_back(data_z); lz.push_back(last_z); cz.push_back(cyc); end
    if (ack_a) ac.push_back(cyc);
    mem_rvalid = 1'b0;
    if ((!burst || n_gnt >= 4) && rq.size() > 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rq.pop_front();
    end
    mem_gnt = !(n_gnt == stall_beat && stall_left > 0);
    if (mreq_a && !mem_gnt) begin sa.push_back(maddr_a); stall_left--; end
    if (mreq_a && mem_gnt) begin ga.push_back(maddr_a); rq.push_back(dat(maddr_a)); n_gnt++; end
  endtask
  task automatic clear();
    rq.delete(); da.delete(); dz.delete(); ga.delete(); sa.delete();
    la.delete(); lz.delete(); ca.delete(); cz.delete(); ac.delete();
    n_gnt = 0; stall_beat = -1; stall_left = 0; burst = 0;
  endtask
  task automatic start_req(input logic [31:3] a, output int n);
    icu_biu_addr = a;
    icu_biu_req  = 1'b1;
    n = cyc;
    step();
    icu_biu_req = 1'b0;
  endtask
  task automatic wait_last(output bit to);
    to = 1'b1;
    for (int i = 0; i < 60 && to; i++) begin
      step();
      if (dv_a && last_a) to = 1'b0;
    end
  endtask
  task automatic test_reset();
    clear();
    reset = 1'b1; icu_biu_req = 1'b0; icu_biu_addr = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) step();
    tests++;
    if ({ack_a, dv_a, last_a, mreq_a} !== 4'b0) begin fails++; $display("FAIL reset_ctrl: got %b want 0000", {ack_a, dv_a, last_a, mreq_a}); end
    tests++;
    if (data_a !== 64'h0) begin fails++; $display("FAIL reset_data: got %h want 0", data_a); end
    reset = 1'b0;
    step();
    tests++;
    if (mreq_a !== 1'b0 || ack_a !== 1'b0) begin fails++; $display("FAIL reset_idle: mem_req %b ack %b want 0 0", mreq_a, ack_a); end
  endtask
  task automatic test_basic_fill();
    int n; bit to;
    clear();
    start_req(29'h2021, n);
    wait_last(to);
    repeat (3) step();
    tests++;
    if (to) begin fails++; $display("FAIL basic_timeout: no last beat within budget"); end
    tests++;
    if (ac.size() != 1 || ac[0] != n + 1) begin fails++; $display("FAIL basic_ack: got %0d acks first at %0d want 1 at %0d", ac.size(), ac.size() ? ac[0] : -1, n + 1); end
    tests++;
    if (ga.size() != 4) begin fails++; $display("FAIL basic_grants: got %0d want 4", ga.size()); end
    for (int i = 0; i < 4 && i < ga.size(); i++) begin
      tests++;
      if (ga[i] !== 29'h2020 + 29'(i)) begin fails++; $display("FAIL basic_addr%0d: got %h want %h", i, ga[i], 29'h2020 + 29'(i)); end
    end
    tests++;
    if (da.size() != 4) begin fails++; $display("FAIL basic_beats: got %0d want 4", da.size()); end
    for (int i = 0; i < 4 && i < da.size(); i++) begin
      tests++;
      if (da[i] !== exp_d[i] || la[i] !== (i == 3) || ca[i] != n + 3 + 2 * i) begin
        fails++; $display("FAIL basic_beat%0d: got %h last %b cyc %0d want %h last %b cyc %0d", i, da[i], la[i], ca[i], exp_d[i], i == 3, n + 3 + 2 * i);
      end
    end
    tests++;
    if (mreq_a !== 1'b0 || dv_a !== 1'b0) begin fails++; $display("FAIL basic_idle: mem_req %b dv %b want 0 0", mreq_a, dv_a); end
  endtask
  task automatic test_beat_gap0();
    int n; bit to;
    clear();
    start_req(29'h2021, n);
    wait_last(to);
    repeat (3) step();
    tests++;
    if (dz.size() != 4 || to) begin fails++; $display("FAIL gap0_beats: got %0d want 4", dz.size()); end
    for (int i = 0; i < 4 && i < dz.size(); i++) begin
      tests++;
      if (dz[i] !== exp_d[i] || lz[i] !== (i == 3) || cz[i] != n + 3 + i) begin
        fails++; $display("FAIL gap0_beat%0d: got %h last %b cyc %0d want %h last %b cyc %0d", i, dz[i], lz[i], cz[i], exp_d[i], i == 3, n + 3 + i);
      end
    end
    tests++;
    if (mreq_z !== 1'b0 || maddr_z !== maddr_a) begin fails++; $display("FAIL gap0_idle: mem_req %b addr %h want 0 %h", mreq_z, maddr_z, maddr_a); end
  endtask
  task automatic test_stall();
    int n; bit to;
    clear();
    stall_beat = 2; stall_left = 5;
    start_req(29'h2021, n);
    wait_last(to);
    repeat (3) step();
    tests++;
    if (sa.size() != 5 || to) begin fails++; $display("FAIL stall_len: got %0d stalled cycles want 5", sa.size()); end
    for (int i = 0; i < sa.size(); i++) begin
      tests++;
      if (sa[i] !== 29'h2022) begin fails++; $display("FAIL stall_addr%0d: got %h want 2022", i, sa[i]); end
    end
    tests++;
    if (ga.size() != 4 || ga[3] !== 29'h2023) begin fails++; $display("FAIL stall_grants: got %0d grants want 4 ending 2023", ga.size()); end
    tests++;
    if (da.size() != 4) begin fails++; $display("FAIL stall_beats: got %0d want 4", da.size()); end
    for (int i = 0; i < 4 && i < da.size(); i++) begin
      tests++;
      if (da[i] !== exp_d[i] || la[i] !== (i == 3) || (i > 0 && ca[i] - ca[i-1] < 2)) begin
        fails++; $display("FAIL stall_beat%0d: got %h last %b cyc %0d want %h last %b spacing>=2", i, da[i], la[i], ca[i], exp_d[i], i == 3);
      end
    end
    tests++;
    if (ca.size() == 4 && ca[3] != n + 12) begin fails++; $display("FAIL stall_last_cyc: got %0d want %0d", ca[3], n + 12); end
  endtask
  task automatic test_burst();
    int n; bit to;
    clear();
    burst = 1'b1;
    start_req(29'h2021, n);
    wait_last(to);
    repeat (3) step();
    tests++;
    if (da.size() != 4 || dz.size() != 4 || to) begin fails++; $display("FAIL burst_beats: got %0d/%0d want 4/4", da.size(), dz.size()); end
    for (int i = 0; i < 4 && i < da.size(); i++) begin
      tests++;
      if (da[i] !== exp_d[i] || la[i] !== (i == 3) || ca[i] != n + 6 + 2 * i) begin
        fails++; $display("FAIL burst_beat%0d: got %h last %b cyc %0d want %h last %b cyc %0d", i, da[i], la[i], ca[i], exp_d[i], i == 3, n + 6 + 2 * i);
      end
    end
    for (int i = 0; i < 4 && i < dz.size(); i++) begin
      tests++;
      if (dz[i] !== exp_d[i] || cz[i] != n + 6 + i) begin fails++; $display("FAIL burst_gap0_beat%0d: got %h cyc %0d want %h cyc %0d", i, dz[i], cz[i], exp_d[i], n + 6 + i); end
    end
  endtask
  task automatic test_back_to_back();
    int n, l; bit to;
    clear();
    start_req(29'h2021, n);
    for (int i = 0; i < 40 && da.size() < 1; i++) step();
    icu_biu_addr = 29'h3000;
    icu_biu_req  = 1'b1;
    step();
    icu_biu_req = 1'b0;
    wait_last(to);
    l = cyc;
    icu_biu_addr = 29'h2022;
    icu_biu_req  = 1'b1;
    repeat (2) step();
    icu_biu_req = 1'b0;
    wait_last(to);
    repeat (3) step();
    tests++;
    if (ac.size() != 2 || ac[1] != l + 2) begin fails++; $display("FAIL b2b_ack: got %0d acks second at %0d want 2 at %0d", ac.size(), ac.size() > 1 ? ac[1] : -1, l + 2); end
    tests++;
    if (ga.size() != 8 || da.size() != 8 || to) begin fails++; $display("FAIL b2b_counts: got %0d grants %0d beats want 8 8", ga.size(), da.size()); end
    for (int i = 4; i < 8 && i < ga.size() && i < da.size(); i++) begin
      tests++;
      if (ga[i] !== 29'h2020 + 29'(i - 4) || da[i] !== exp_d[i-4]) begin
        fails++; $display("FAIL b2b_beat%0d: got addr %h data %h want %h %h", i - 4, ga[i], da[i], 29'h2020 + 29'(i - 4), exp_d[i-4]);
      end
    end
  endtask
  task automatic test_reset_mid_fill();
    int n; bit to;
    clear();
    start_req(29'h2021, n);
    for (int i = 0; i < 40 && da.size() < 2; i++) step();
    reset = 1'b1;
    step();
    tests++;
    if ({ack_a, dv_a, last_a, mreq_a} !== 4'b0 || data_a !== 64'h0) begin
      fails++; $display("FAIL midrst_outputs: got ctrl %b data %h want 0000 0", {ack_a, dv_a, last_a, mreq_a}, data_a);
    end
    reset = 1'b0;
    rq.push_back(64'hdead_beef_dead_beef);
    repeat (10) step();
    tests++;
    if (da.size() != 2 || ac.size() != 1 || mreq_a !== 1'b0) begin
      fails++; $display("FAIL midrst_quiet: got %0d beats %0d acks mem_req %b want 2 1 0", da.size(), ac.size(), mreq_a);
    end
    clear();
    start_req(29'h2021, n);
    wait_last(to);
    repeat (3) step();
    tests++;
    if (da.size() != 4 || da[0] !== exp_d[0] || da[3] !== exp_d[3] || to) begin
      fails++; $display("FAIL midrst_refill: got %0d beats first %h want 4 first %h", da.size(), da.size() ? da[0] : 64'h0, exp_d[0]);
    end
  endtask
  initial begin
    exp_d[0] = 64'hbbbb_bbbb_bbbb_bbbb;
    exp_d[1] = 64'hcccc_cccc_cccc_cccc;
    exp_d[2] = 64'hdddd_dddd_dddd_dddd;
    exp_d[3] = 64'heeee_eeee_eeee_eeee;
    tests = 0; fails = 0; cyc = 0;
    test_reset();
    test_basic_fill();
    test_beat_gap0();
    test_stall();
    test_burst();
    test_back_to_back();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
